// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side endpoint of the instruction/data memory bus. It accepts LOAD and
// STORE commands and acknowledges each one in the same cycle with a nonzero
// tag. Each accepted LOAD returns its tag and data exactly MEM_LATENCY cycles
// later. The backing store is an array of 64-bit words.
//
// Parameters
//   MEM_LATENCY : cycles from load acceptance to data return (1..14)
//   MEM_DEPTH   : number of 64-bit words held
//   ADDR_W      : byte address width
//
// Ports
//   clock             in   system clock, rising edge
//   reset             in   asynchronous, active-high reset
//   proc2mem_command  in   2'b00 NONE, 2'b01 LOAD, 2'b10 STORE, 2'b11 as NONE
//   proc2mem_addr     in   byte address; bits [2:0] are ignored
//   proc2mem_data     in   store data
//   mem2proc_response out  accept tag for this cycle's command; 0 = rejected
//   mem2proc_data     out  returned load data; 0 when nothing is returned
//   mem2proc_tag      out  tag of the returned load; 0 = no return this cycle
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_DEPTH   = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        proc2mem_command,
    input  logic [ADDR_W-1:0] proc2mem_addr,
    input  logic [63:0]       proc2mem_data,
    output logic [3:0]        mem2proc_response,
    output logic [63:0]       mem2proc_data,
    output logic [3:0]        mem2proc_tag
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 14) begin : g_bad_latency
        $error("mem_responder: MEM_LATENCY must lie within 1..14");
    end

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_STORE = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // One past the last legal byte address. The comparison is done one bit
    // wider than the address so the limit itself is representable.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_DEPTH) << 3;

    cmd_e             cmd;
    logic             in_range;
    logic             is_load;
    logic             is_store;
    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [63:0]      rd_word;
    logic [3:0]       tag_cnt;

    logic [63:0] mem [MEM_DEPTH];

    // A stage's tag doubles as its valid bit: the tag counter never issues 0,
    // so a zero tag marks an empty slot. Empty slots also carry zero data,
    // which lets the final stage drive the outputs directly.
    logic [3:0]  tag_p  [MEM_LATENCY];
    logic [63:0] data_p [MEM_LATENCY];

    function automatic logic [3:0] next_tag(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    assign cmd      = cmd_e'(proc2mem_command);
    assign word_idx = proc2mem_addr[IDX_W+2:3];
    assign rd_word  = mem[word_idx];

    always_comb begin
        in_range          = ({1'b0, proc2mem_addr} < ADDR_LIMIT);
        is_load           = (cmd == CMD_LOAD);
        is_store          = (cmd == CMD_STORE);
        accept            = !reset && in_range && (is_load || is_store);
        mem2proc_response = accept ? tag_cnt : 4'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_cnt <= 4'd1;
        end else if (accept) begin
            tag_cnt <= next_tag(tag_cnt);
        end
    end

    // Word store: not reset; contents are established by STOREs.
    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem[word_idx] <= proc2mem_data;
        end
    end

    // Latency pipeline: stage 0 captures the load snapshot at the accepting
    // edge, later stages shift one per cycle, the last stage drives the outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tag_p[i]  <= 4'd0;
                data_p[i] <= 64'd0;
            end
        end else begin
            tag_p[0]  <= (accept && is_load) ? tag_cnt : 4'd0;
            data_p[0] <= (accept && is_load) ? rd_word : 64'd0;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tag_p[i]  <= tag_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign mem2proc_tag  = tag_p[MEM_LATENCY-1];
    assign mem2proc_data = data_p[MEM_LATENCY-1];

endmodule
